// File: rtl/mc_ctrl_pkg.sv
// Purpose : shared encodings for the multi-cycle MIPS control unit (states, opcodes, funct, ALU/mux selects).
// Latency : n/a (declarations only).
// Backpr. : n/a.
package mc_ctrl_pkg;

    // Controller states, one per instruction phase.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        DIVEX  = 4'd12,
        DIVWB  = 4'd13
    } state_t;

    // Opcodes.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_DIV   = 6'b001001;

    // R-type funct codes.
    localparam logic [5:0] FN_ADD    = 6'b100000;
    localparam logic [5:0] FN_SUB    = 6'b100010;
    localparam logic [5:0] FN_AND    = 6'b100100;
    localparam logic [5:0] FN_OR     = 6'b100101;
    localparam logic [5:0] FN_SLT    = 6'b101010;
    localparam logic [5:0] FN_CUSTOM = 6'b111111;

    // ALU operations (3-bit native, zero-extended by users to ALUCTRL_W).
    localparam logic [2:0] ALU_AND    = 3'b000;
    localparam logic [2:0] ALU_OR     = 3'b001;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_CUSTOM = 3'b011;
    localparam logic [2:0] ALU_DIV    = 3'b100;
    localparam logic [2:0] ALU_SUB    = 3'b110;
    localparam logic [2:0] ALU_SLT    = 3'b111;

    // ALU B-operand select.
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Divide cycle counter width; covers DIV_CYCLES up to 255.
    localparam int DIV_CNT_W = 8;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Purpose : R-type funct -> ALUControl decode, flags unknown funct codes.
// Latency : combinational.
// Backpr. : none.
// Ports   : funct (in, 6) ; alu_ctrl (out, ALUCTRL_W) ; illegal (out, 1, unknown funct).
module alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 illegal
);

    always_comb begin
        // Unknown funct drives an all-ones ALU code alongside the illegal flag.
        alu_ctrl = '1;
        illegal  = 1'b0;
        case (funct)
            FN_ADD:    alu_ctrl = ALUCTRL_W'(ALU_ADD);
            FN_SUB:    alu_ctrl = ALUCTRL_W'(ALU_SUB);
            FN_AND:    alu_ctrl = ALUCTRL_W'(ALU_AND);
            FN_OR:     alu_ctrl = ALUCTRL_W'(ALU_OR);
            FN_SLT:    alu_ctrl = ALUCTRL_W'(ALU_SLT);
            FN_CUSTOM: alu_ctrl = ALUCTRL_W'(ALU_CUSTOM);
            default:   illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Purpose : multi-cycle MIPS control unit; Moore FSM sequencing fetch/decode/execute/memory/writeback plus divide.
// Latency : lw 5, sw/R/addi 4, beq/j 3, div DIV_CYCLES+3 cycles (mem_ready held high).
// Backpr. : FETCH, MEMRD and MEMWR hold state until mem_ready; DIVEX holds for DIV_CYCLES cycles.
// Ports   : clk, rst (sync, active high); op/funct from IR; zero, mem_ready from datapath/memory;
//           datapath strobes PCWrite, PCWriteCond, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg;
//           mux selects ALUSrcA, ALUSrcB, PCSrc, ALUControl; status div_busy, illegal_op.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter int DIV_CYCLES = 32,
    parameter bit ENABLE_DIV = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 IorD,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 div_busy,
    output logic                 illegal_op
);

    localparam logic [DIV_CNT_W-1:0] DIV_CNT_INIT = DIV_CNT_W'(DIV_CYCLES - 1);
    localparam logic [ALUCTRL_W-1:0] ALUC_ADD     = ALUCTRL_W'(ALU_ADD);
    localparam logic [ALUCTRL_W-1:0] ALUC_SUB     = ALUCTRL_W'(ALU_SUB);
    localparam logic [ALUCTRL_W-1:0] ALUC_DIV     = ALUCTRL_W'(ALU_DIV);

    state_t               state_q, state_d;
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
    // Remembers an unknown funct seen in EXEC so ALUWB suppresses the write.
    logic                 funct_bad_q, funct_bad_d;

    logic                 op_illegal;
    logic [ALUCTRL_W-1:0] exec_alu_ctrl;
    logic                 exec_funct_bad;

    // The branch condition is applied in the datapath (PCWriteCond & zero);
    // the flag is carried on this interface but not needed by the sequencer.
    logic                 unused_zero;
    assign unused_zero = zero;

    alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .funct    (funct),
        .alu_ctrl (exec_alu_ctrl),
        .illegal  (exec_funct_bad)
    );

    // Opcode legality; div is only legal when the divider is built in.
    always_comb begin
        op_illegal = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_illegal = 1'b0;
            OP_DIV:  op_illegal = !ENABLE_DIV;
            default: op_illegal = 1'b1;
        endcase
    end

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        funct_bad_d = funct_bad_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_DIV: begin
                        if (ENABLE_DIV) begin
                            state_d   = DIVEX;
                            div_cnt_d = DIV_CNT_INIT;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC: begin
                state_d     = ALUWB;
                funct_bad_d = exec_funct_bad;
            end
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            JUMP:   state_d = FETCH;
            // Counter was loaded with DIV_CYCLES-1 on entry, so reaching zero
            // marks the last divide cycle.
            DIVEX: begin
                if (div_cnt_q == '0) begin
                    state_d = DIVWB;
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            DIVWB:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            div_cnt_q   <= '0;
            funct_bad_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            funct_bad_q <= funct_bad_d;
        end
    end

    // Moore output decode; only FETCH strobes (mem_ready), EXEC ALU op (funct)
    // and illegal_op (op/funct) look at inputs.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REGB;
        PCSrc       = PCSRC_ALU;
        ALUControl  = '0;
        div_busy    = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALUC_ADD;
            end
            DECODE: begin
                ALUSrcB    = SRCB_IMMSH;
                ALUControl = ALUC_ADD;
                illegal_op = op_illegal;
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALUC_ADD;
            end
            MEMRD: IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = exec_alu_ctrl;
                illegal_op = exec_funct_bad;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = !funct_bad_q;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUControl  = ALUC_SUB;
                PCWriteCond = 1'b1;
                PCSrc       = PCSRC_ALUOUT;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALUC_ADD;
            end
            ADDIWB: RegWrite = 1'b1;
            JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_JUMP;
            end
            DIVEX: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALUC_DIV;
                div_busy   = 1'b1;
            end
            DIVWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Purpose : randomized + directed bench for mc_controller with a per-cycle expected-output scoreboard.
// Latency : n/a.
// Backpr. : n/a.
module tb_mc_controller;

    localparam int DIVC = 4;

    // Phase identifiers of the reference model (one per instruction step).
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_ADDIEX = 9,
                   P_ADDIWB = 10, P_JUMP = 11, P_DIVEX = 12, P_DIVWB = 13;

    localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                           O_BEQ = 6'b000100, O_ADDI = 6'b001000, O_J = 6'b000010,
                           O_DIV = 6'b001001;

    typedef struct packed {
        logic       pcw, pcwc, iord, irw, memw, regw, regdst, m2r, asa;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        logic       busy, ill;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, zero, mem_ready;
    logic [5:0] op, funct;

    logic PCWrite_a, PCWriteCond_a, IorD_a, IRWrite_a, MemWrite_a, RegWrite_a, RegDst_a, MemtoReg_a, ALUSrcA_a;
    logic [1:0] ALUSrcB_a, PCSrc_a;
    logic [2:0] ALUControl_a;
    logic div_busy_a, illegal_op_a;
    logic PCWrite_b, PCWriteCond_b, IorD_b, IRWrite_b, MemWrite_b, RegWrite_b, RegDst_b, MemtoReg_b, ALUSrcA_b;
    logic [1:0] ALUSrcB_b, PCSrc_b;
    logic [2:0] ALUControl_b;
    logic div_busy_b, illegal_op_b;

    mc_controller #(.ALUCTRL_W(3), .DIV_CYCLES(DIVC), .ENABLE_DIV(1'b1)) u_dut (
        .clk(clk), .rst(rst_a), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite_a), .PCWriteCond(PCWriteCond_a), .IorD(IorD_a), .IRWrite(IRWrite_a),
        .MemWrite(MemWrite_a), .RegWrite(RegWrite_a), .RegDst(RegDst_a), .MemtoReg(MemtoReg_a),
        .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a), .PCSrc(PCSrc_a), .ALUControl(ALUControl_a),
        .div_busy(div_busy_a), .illegal_op(illegal_op_a)
    );

    mc_controller #(.ALUCTRL_W(3), .DIV_CYCLES(DIVC), .ENABLE_DIV(1'b0)) u_dut_nodiv (
        .clk(clk), .rst(rst_b), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite_b), .PCWriteCond(PCWriteCond_b), .IorD(IorD_b), .IRWrite(IRWrite_b),
        .MemWrite(MemWrite_b), .RegWrite(RegWrite_b), .RegDst(RegDst_b), .MemtoReg(MemtoReg_b),
        .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .PCSrc(PCSrc_b), .ALUControl(ALUControl_b),
        .div_busy(div_busy_b), .illegal_op(illegal_op_b)
    );

    out_t act_a, act_b;
    assign act_a = {PCWrite_a, PCWriteCond_a, IorD_a, IRWrite_a, MemWrite_a, RegWrite_a, RegDst_a,
                    MemtoReg_a, ALUSrcA_a, ALUSrcB_a, PCSrc_a, ALUControl_a, div_busy_a, illegal_op_a};
    assign act_b = {PCWrite_b, PCWriteCond_b, IorD_b, IRWrite_b, MemWrite_b, RegWrite_b, RegDst_b,
                    MemtoReg_b, ALUSrcA_b, ALUSrcB_b, PCSrc_b, ALUControl_b, div_busy_b, illegal_op_b};

    // Scoreboard: one expected output vector per clock cycle, tagged with the DUT it targets.
    out_t  exp_q[$];
    string name_q[$];
    bit    dut_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // ---------------- reference model ----------------
    function automatic bit funct_ok(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010) || (f == 6'b111111);
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            6'b111111: return 3'b011;
            default:   return 3'b111;
        endcase
    endfunction

    function automatic bit op_known(input logic [5:0] o, input bit en_div);
        return (o == O_R) || (o == O_LW) || (o == O_SW) || (o == O_BEQ) ||
               (o == O_ADDI) || (o == O_J) || (en_div && o == O_DIV);
    endfunction

    function automatic string pname(input int ph);
        case (ph)
            P_FETCH: return "fetch";   P_DECODE: return "decode"; P_MEMADR: return "memadr";
            P_MEMRD: return "memrd";   P_MEMWB:  return "memwb";  P_MEMWR:  return "memwr";
            P_EXEC:  return "exec";    P_ALUWB:  return "aluwb";  P_BRANCH: return "branch";
            P_ADDIEX: return "addiex"; P_ADDIWB: return "addiwb"; P_JUMP:   return "jump";
            P_DIVEX: return "divex";   default:  return "divwb";
        endcase
    endfunction

    // Expected outputs for one phase, straight from the control table.
    function automatic out_t phase_out(input int ph, input bit mr, input logic [5:0] f, input bit bad);
        out_t e;
        e = '0;
        case (ph)
            P_FETCH:  begin e.irw = mr; e.pcw = mr; e.asb = 2'b01; e.alu = 3'b010; end
            P_DECODE: begin e.asb = 2'b11; e.alu = 3'b010; e.ill = bad; end
            P_MEMADR: begin e.asa = 1'b1; e.asb = 2'b10; e.alu = 3'b010; end
            P_MEMRD:  e.iord = 1'b1;
            P_MEMWB:  begin e.m2r = 1'b1; e.regw = 1'b1; end
            P_MEMWR:  begin e.iord = 1'b1; e.memw = 1'b1; end
            P_EXEC:   begin e.asa = 1'b1; e.alu = alu_of(f); e.ill = bad; end
            P_ALUWB:  begin e.regdst = 1'b1; e.regw = !bad; end
            P_BRANCH: begin e.asa = 1'b1; e.alu = 3'b110; e.pcwc = 1'b1; e.pcs = 2'b01; end
            P_ADDIEX: begin e.asa = 1'b1; e.asb = 2'b10; e.alu = 3'b010; end
            P_ADDIWB: e.regw = 1'b1;
            P_JUMP:   begin e.pcw = 1'b1; e.pcs = 2'b10; end
            P_DIVEX:  begin e.asa = 1'b1; e.alu = 3'b100; e.busy = 1'b1; end
            default:  begin e.regdst = 1'b1; e.regw = 1'b1; end
        endcase
        return e;
    endfunction

    // mem_ready for the n-th cycle of a wait: exactly `lows` low cycles, or random (bounded) when lows < 0.
    function automatic bit pick(input int lows, input int n);
        if (lows >= 0) return (n >= lows);
        return (n >= 6) || ($urandom_range(0, 2) != 0);
    endfunction

    // ---------------- stimulus ----------------
    task automatic cycle(input int ph, input bit dut, input bit mr,
                         input logic [5:0] o, input logic [5:0] f, input bit bad);
        mem_ready = mr;
        op        = o;
        funct     = f;
        zero      = 1'($urandom_range(0, 1));
        exp_q.push_back(phase_out(ph, mr, f, bad));
        name_q.push_back(pname(ph));
        dut_q.push_back(dut);
        @(posedge clk);
        #1;
    endtask

    // FETCH ignores op/funct, so drive garbage there.
    task automatic do_fetch(input bit dut, input int lows);
        int n;
        bit mr;
        n = 0;
        do begin
            mr = pick(lows, n);
            cycle(P_FETCH, dut, mr, 6'($urandom), 6'($urandom), 1'b0);
            n++;
        end while (!mr);
    endtask

    task automatic run_instr(input bit dut, input logic [5:0] o, input logic [5:0] f,
                             input int lows, input bit en_div);
        int n;
        bit mr;
        bit fbad;
        fbad = !funct_ok(f);
        do_fetch(dut, lows);
        cycle(P_DECODE, dut, 1'($urandom_range(0, 1)), o, f, !op_known(o, en_div));
        if (op_known(o, en_div)) begin
            case (o)
                O_LW, O_SW: begin
                    cycle(P_MEMADR, dut, 1'($urandom_range(0, 1)), o, f, 1'b0);
                    n = 0;
                    do begin
                        mr = pick(lows, n);
                        cycle((o == O_LW) ? P_MEMRD : P_MEMWR, dut, mr, o, f, 1'b0);
                        n++;
                    end while (!mr);
                    if (o == O_LW) cycle(P_MEMWB, dut, 1'($urandom_range(0, 1)), o, f, 1'b0);
                end
                O_R: begin
                    cycle(P_EXEC, dut, 1'($urandom_range(0, 1)), o, f, fbad);
                    cycle(P_ALUWB, dut, 1'($urandom_range(0, 1)), o, f, fbad);
                end
                O_BEQ: cycle(P_BRANCH, dut, 1'($urandom_range(0, 1)), o, f, 1'b0);
                O_ADDI: begin
                    cycle(P_ADDIEX, dut, 1'($urandom_range(0, 1)), o, f, 1'b0);
                    cycle(P_ADDIWB, dut, 1'($urandom_range(0, 1)), o, f, 1'b0);
                end
                O_J: cycle(P_JUMP, dut, 1'($urandom_range(0, 1)), o, f, 1'b0);
                default: begin
                    for (int i = 0; i < DIVC; i++)
                        cycle(P_DIVEX, dut, 1'($urandom_range(0, 1)), o, f, 1'b0);
                    cycle(P_DIVWB, dut, 1'($urandom_range(0, 1)), o, f, 1'b0);
                end
            endcase
        end
    endtask

    task automatic run_random(input bit dut, input bit en_div);
        logic [5:0] o, f;
        int r;
        r = $urandom_range(0, 9);
        f = 6'($urandom);
        case (r)
            0: begin o = O_R; f = (($urandom_range(0, 1) == 1) ? 6'b100000 : 6'b101010); end
            1: o = O_R;
            2, 9: o = O_LW;
            3: o = O_SW;
            4: o = O_BEQ;
            5: o = O_ADDI;
            6: o = O_J;
            7: o = O_DIV;
            default: begin
                o = 6'($urandom);
                if (op_known(o, 1'b1)) o = 6'b111110;
            end
        endcase
        run_instr(dut, o, f, -1, en_div);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  e, a;
            string nm;
            bit    d;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            d  = dut_q.pop_front();
            a  = d ? act_b : act_a;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s (dut%0d) t=%0t: got %b required %b", nm, d, $time, a, e);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Still in reset: state already forced to FETCH, mem_ready low -> no strobes.
        cycle(P_FETCH, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0);
        rst_a = 1'b0;

        run_instr(1'b0, O_LW, 6'b000000, 0, 1'b1);          // lw, ready throughout
        run_instr(1'b0, O_SW, 6'b000000, 3, 1'b1);          // sw, 3 wait cycles
        run_instr(1'b0, O_R, 6'b101010, 0, 1'b1);           // slt
        run_instr(1'b0, O_R, 6'b000111, 0, 1'b1);           // illegal funct
        run_instr(1'b0, O_DIV, 6'b000000, 0, 1'b1);         // divide
        run_instr(1'b0, 6'b111111, 6'b000000, 0, 1'b1);     // illegal opcode
        run_instr(1'b0, O_BEQ, 6'b000000, 0, 1'b1);
        run_instr(1'b0, O_J, 6'b000000, 0, 1'b1);
        run_instr(1'b0, O_ADDI, 6'b000000, 0, 1'b1);

        // Reset in the middle of a divide (second DIVEX cycle, counter at 2).
        do_fetch(1'b0, 0);
        cycle(P_DECODE, 1'b0, 1'b1, O_DIV, 6'b000000, 1'b0);
        cycle(P_DIVEX, 1'b0, 1'b1, O_DIV, 6'b000000, 1'b0);
        rst_a = 1'b1;
        cycle(P_DIVEX, 1'b0, 1'b1, O_DIV, 6'b000000, 1'b0);
        rst_a = 1'b0;
        cycle(P_FETCH, 1'b0, 1'b0, O_DIV, 6'b000000, 1'b0);
        run_instr(1'b0, O_DIV, 6'b000000, 0, 1'b1);         // divide runs clean after abort

        for (int i = 0; i < 150; i++) run_random(1'b0, 1'b1);

        // Divider-less build: div decodes as illegal.
        rst_a = 1'b1;
        rst_b = 1'b0;
        run_instr(1'b1, O_DIV, 6'b000000, 0, 1'b0);
        run_instr(1'b1, O_LW, 6'b000000, 0, 1'b0);
        for (int i = 0; i < 30; i++) run_random(1'b1, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
